// File: rtl/ball_motion_ctrl.sv
// Ball motion controller: serve delay, per-frame movement, wall reflection,
// paddle hits with speed-up, miss scoring and game-over/restart handling.
module ball_motion_ctrl #(
    parameter int FIELD_W        = 640,
    parameter int FIELD_H        = 480,
    parameter int BALL_SIZE      = 8,
    parameter int MAX_SPEED      = 4,
    parameter int HITS_PER_LEVEL = 4,
    parameter int SERVE_DELAY    = 60,
    parameter int WIN_SCORE      = 9,
    parameter int XW             = 10,
    parameter int YW             = 10,
    parameter int SW             = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic          hit_left,
    input  logic          hit_right,
    input  logic          start,
    output logic [XW-1:0] ball_x,
    output logic [YW-1:0] ball_y,
    output logic          dir_x,
    output logic          dir_y,
    output logic [2:0]    speed,
    output logic [SW-1:0] score_left,
    output logic [SW-1:0] score_right,
    output logic          serving,
    output logic          game_over,
    output logic          point_pulse
);

    localparam int DW = $clog2(SERVE_DELAY + 1);
    localparam int HW = $clog2(HITS_PER_LEVEL + 1);
    localparam logic [XW-1:0] X_MAX = XW'(FIELD_W - BALL_SIZE);
    localparam logic [YW-1:0] Y_MAX = YW'(FIELD_H - BALL_SIZE);
    localparam logic [XW-1:0] X_CTR = XW'((FIELD_W - BALL_SIZE) / 2);
    localparam logic [YW-1:0] Y_CTR = YW'((FIELD_H - BALL_SIZE) / 2);

    typedef enum logic [1:0] {SERVE, MOVE, SCORED, GAME_OVER} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   delay_cnt, delay_nxt;
    logic [HW-1:0]   hit_cnt, hit_cnt_nxt;
    logic            latch_l, latch_l_nxt, latch_r, latch_r_nxt;
    logic            scorer_left, scorer_left_nxt;
    logic [XW-1:0]   x_nxt;
    logic [YW-1:0]   y_nxt;
    logic            dir_x_nxt, dir_y_nxt;
    logic [2:0]      speed_nxt;
    logic [SW-1:0]   score_l_nxt, score_r_nxt;

    logic            hit_l, hit_r, acc_l, acc_r;
    logic [XW-1:0]   spd_x;
    logic [YW-1:0]   spd_y;
    logic [SW-1:0]   score_l_inc, score_r_inc;

    assign hit_l       = latch_l | hit_left;
    assign hit_r       = latch_r | hit_right;
    assign acc_l       = hit_l & ~dir_x;
    assign acc_r       = hit_r & dir_x;
    assign spd_x       = XW'(speed);
    assign spd_y       = YW'(speed);
    assign score_l_inc = score_left + 1'b1;
    assign score_r_inc = score_right + 1'b1;

    assign serving     = (state == SERVE);
    assign game_over   = (state == GAME_OVER);
    assign point_pulse = (state == SCORED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SERVE;
            delay_cnt   <= '0;
            hit_cnt     <= '0;
            latch_l     <= 1'b0;
            latch_r     <= 1'b0;
            scorer_left <= 1'b0;
            ball_x      <= X_CTR;
            ball_y      <= Y_CTR;
            dir_x       <= 1'b0;
            dir_y       <= 1'b0;
            speed       <= 3'd1;
            score_left  <= '0;
            score_right <= '0;
        end else begin
            state       <= state_nxt;
            delay_cnt   <= delay_nxt;
            hit_cnt     <= hit_cnt_nxt;
            latch_l     <= latch_l_nxt;
            latch_r     <= latch_r_nxt;
            scorer_left <= scorer_left_nxt;
            ball_x      <= x_nxt;
            ball_y      <= y_nxt;
            dir_x       <= dir_x_nxt;
            dir_y       <= dir_y_nxt;
            speed       <= speed_nxt;
            score_left  <= score_l_nxt;
            score_right <= score_r_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        delay_nxt       = delay_cnt;
        hit_cnt_nxt     = hit_cnt;
        latch_l_nxt     = hit_l;
        latch_r_nxt     = hit_r;
        scorer_left_nxt = scorer_left;
        x_nxt           = ball_x;
        y_nxt           = ball_y;
        dir_x_nxt       = dir_x;
        dir_y_nxt       = dir_y;
        speed_nxt       = speed;
        score_l_nxt     = score_left;
        score_r_nxt     = score_right;

        case (state)
            SERVE: begin
                x_nxt     = X_CTR;
                y_nxt     = Y_CTR;
                speed_nxt = 3'd1;
                if (frame_tick) begin
                    latch_l_nxt = 1'b0;
                    latch_r_nxt = 1'b0;
                    if (delay_cnt == DW'(SERVE_DELAY - 1)) begin
                        delay_nxt = '0;
                        state_nxt = MOVE;
                    end else begin
                        delay_nxt = delay_cnt + 1'b1;
                    end
                end
            end

            MOVE: begin
                if (frame_tick) begin
                    latch_l_nxt = 1'b0;
                    latch_r_nxt = 1'b0;

                    if (!dir_y) begin
                        if (ball_y < spd_y) begin
                            y_nxt     = '0;
                            dir_y_nxt = 1'b1;
                        end else begin
                            y_nxt = ball_y - spd_y;
                        end
                    end else begin
                        if ({1'b0, ball_y} + {1'b0, spd_y} > {1'b0, Y_MAX}) begin
                            y_nxt     = Y_MAX;
                            dir_y_nxt = 1'b0;
                        end else begin
                            y_nxt = ball_y + spd_y;
                        end
                    end

                    // An accepted hit reverses X and freezes it for this tick.
                    if (acc_l || acc_r) begin
                        dir_x_nxt = ~dir_x;
                        if (hit_cnt == HW'(HITS_PER_LEVEL - 1)) begin
                            hit_cnt_nxt = '0;
                            if (speed < 3'(MAX_SPEED))
                                speed_nxt = speed + 1'b1;
                        end else begin
                            hit_cnt_nxt = hit_cnt + 1'b1;
                        end
                    end else if (!dir_x && ball_x < spd_x) begin
                        scorer_left_nxt = 1'b0;
                        state_nxt       = SCORED;
                    end else if (dir_x && ({1'b0, ball_x} + {1'b0, spd_x} > {1'b0, X_MAX})) begin
                        scorer_left_nxt = 1'b1;
                        state_nxt       = SCORED;
                    end else if (dir_x) begin
                        x_nxt = ball_x + spd_x;
                    end else begin
                        x_nxt = ball_x - spd_x;
                    end
                end
            end

            SCORED: begin
                dir_x_nxt   = scorer_left;
                delay_nxt   = '0;
                hit_cnt_nxt = '0;
                state_nxt   = SERVE;
                if (scorer_left) begin
                    score_l_nxt = score_l_inc;
                    if (score_l_inc == SW'(WIN_SCORE))
                        state_nxt = GAME_OVER;
                end else begin
                    score_r_nxt = score_r_inc;
                    if (score_r_inc == SW'(WIN_SCORE))
                        state_nxt = GAME_OVER;
                end
                if (state_nxt == SERVE) begin
                    x_nxt     = X_CTR;
                    y_nxt     = Y_CTR;
                    speed_nxt = 3'd1;
                end
            end

            GAME_OVER: begin
                latch_l_nxt = 1'b0;
                latch_r_nxt = 1'b0;
                if (start) begin
                    score_l_nxt = '0;
                    score_r_nxt = '0;
                    delay_nxt   = '0;
                    hit_cnt_nxt = '0;
                    x_nxt       = X_CTR;
                    y_nxt       = Y_CTR;
                    speed_nxt   = 3'd1;
                    state_nxt   = SERVE;
                end
            end

            default: state_nxt = SERVE;
        endcase
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed-vector bench for ball_motion_ctrl at default parameters; every
// expected value below was traced by hand from the serve position (316,236).
module tb_ball_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       hit_left = 1'b0;
    logic       hit_right = 1'b0;
    logic       start = 1'b0;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       dir_x;
    logic       dir_y;
    logic [2:0] speed;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       serving;
    logic       game_over;
    logic       point_pulse;

    int vectors = 0;
    int miscompares = 0;

    ball_motion_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .hit_left   (hit_left),
        .hit_right  (hit_right),
        .start      (start),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .dir_x      (dir_x),
        .dir_y      (dir_y),
        .speed      (speed),
        .score_left (score_left),
        .score_right(score_right),
        .serving    (serving),
        .game_over  (game_over),
        .point_pulse(point_pulse)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs; returns at the following negedge, after the edge consumed them.
    task automatic applyStimulus(input bit tick, input bit hl, input bit hr, input bit st);
        @(negedge clk);
        frame_tick = tick;
        hit_left   = hl;
        hit_right  = hr;
        start      = st;
        @(negedge clk);
        frame_tick = 1'b0;
        hit_left   = 1'b0;
        hit_right  = 1'b0;
        start      = 1'b0;
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hitTick(input bit hl, input bit hr);
        applyStimulus(1'b0, hl, hr, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_x"}, ball_x, 316);
        checkOutput({tag, "_y"}, ball_y, 236);
        checkOutput({tag, "_dirx"}, dir_x, 0);
        checkOutput({tag, "_diry"}, dir_y, 0);
        checkOutput({tag, "_speed"}, speed, 1);
        checkOutput({tag, "_scl"}, score_left, 0);
        checkOutput({tag, "_scr"}, score_right, 0);
        checkOutput({tag, "_serving"}, serving, 1);
        checkOutput({tag, "_gameover"}, game_over, 0);
        checkOutput({tag, "_pulse"}, point_pulse, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkResetValues("reset");

        // Serve delay then the first two motion ticks.
        runTicks(59);
        checkOutput("serve_59", serving, 1);
        runTicks(1);
        checkOutput("serve_60", serving, 0);
        checkOutput("serve_60_x", ball_x, 316);
        runTicks(1);
        checkOutput("first_move_x", ball_x, 315);
        checkOutput("first_move_y", ball_y, 235);
        runTicks(1);

        // Sixteen alternating accepted hits: speed 1 -> 2 after four, saturates at 4.
        for (int h = 1; h <= 16; h++) begin
            hitTick(h[0], ~h[0]);
            if (h == 4) checkOutput("speed_after_4", speed, 2);
            if (h == 12) checkOutput("speed_after_12", speed, 4);
        end
        checkOutput("speed_after_16", speed, 4);
        checkOutput("hits_x_hold", ball_x, 314);
        checkOutput("hits_y", ball_y, 194);
        checkOutput("hits_dirx", dir_x, 0);

        // Accepted left hit, then a wrong-direction left hit, then right, then none.
        hitTick(1'b1, 1'b0);
        checkOutput("hitA_dirx", dir_x, 1);
        hitTick(1'b1, 1'b0);
        checkOutput("wrongdir_dirx", dir_x, 1);
        checkOutput("wrongdir_x", ball_x, 318);
        hitTick(1'b0, 1'b1);
        checkOutput("hitC_dirx", dir_x, 0);
        checkOutput("hitC_x", ball_x, 318);
        runTicks(1);
        checkOutput("latch_clear_dirx", dir_x, 0);
        checkOutput("latch_clear_x", ball_x, 314);
        checkOutput("latch_clear_y", ball_y, 178);

        // Top wall from y=2 at speed 4.
        runTicks(44);
        checkOutput("pre_wall_y", ball_y, 2);
        checkOutput("pre_wall_diry", dir_y, 0);
        runTicks(1);
        checkOutput("top_wall_y", ball_y, 0);
        checkOutput("top_wall_diry", dir_y, 1);
        checkOutput("top_wall_x", ball_x, 134);

        // Left miss from x=2 at speed 4.
        runTicks(33);
        checkOutput("pre_miss_x", ball_x, 2);
        runTicks(1);
        checkOutput("left_miss_pulse", point_pulse, 1);
        checkOutput("left_miss_serving", serving, 0);
        @(negedge clk);
        checkOutput("left_miss_pulse_off", point_pulse, 0);
        checkOutput("left_miss_scr", score_right, 1);
        checkOutput("left_miss_dirx", dir_x, 0);
        checkOutput("left_miss_serving2", serving, 1);
        checkOutput("left_miss_x", ball_x, 316);
        checkOutput("left_miss_speed", speed, 1);

        // Nine right-edge misses give the left player the game.
        for (int k = 1; k <= 9; k++) begin
            runTicks(60);
            checkOutput("round_serve_done", serving, 0);
            if (k == 1) begin
                hitTick(1'b1, 1'b0);
                checkOutput("round_hit_dirx", dir_x, 1);
                checkOutput("round_hit_x", ball_x, 316);
            end
            runTicks(316);
            checkOutput("right_edge_x", ball_x, 632);
            runTicks(1);
            checkOutput("right_miss_pulse", point_pulse, 1);
            @(negedge clk);
            checkOutput("score_left", score_left, k);
            checkOutput("game_over_flag", game_over, (k == 9) ? 1 : 0);
            checkOutput("dirx_after_left", dir_x, 1);
        end

        // Game over holds everything.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("go_hold_x", ball_x, 632);
        checkOutput("go_hold_flag", game_over, 1);
        checkOutput("go_hold_scl", score_left, 9);
        checkOutput("go_hold_scr", score_right, 1);
        checkOutput("go_hold_pulse", point_pulse, 0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("restart_serving", serving, 1);
        checkOutput("restart_gameover", game_over, 0);
        checkOutput("restart_scl", score_left, 0);
        checkOutput("restart_scr", score_right, 0);
        checkOutput("restart_x", ball_x, 316);

        // Into MOVE, then reset mid-flight.
        runTicks(63);
        checkOutput("post_restart_x", ball_x, 319);
        @(negedge clk);
        reset      = 1'b1;
        frame_tick = 1'b1;
        hit_left   = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        frame_tick = 1'b0;
        hit_left   = 1'b0;
        checkResetValues("midmove_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
